// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel digit editor: editor state,
// key/switch bit positions and a digit-replace helper.
package panel_pkg;

    typedef enum logic {
        ST_VIEW = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    localparam int KEY_DIGIT = 0;
    localparam int KEY_EDIT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_LEFT  = 3;

    localparam int SW_DOWN = 0;
    localparam int SW_LOAD = 7;

    // Replace one hex digit of a 32-bit value; neighbouring digits untouched.
    function automatic logic [31:0] set_digit(input logic [31:0] v,
                                              input logic [2:0]  idx,
                                              input logic [3:0]  d);
        logic [31:0] r;
        r = v;
        r[int'(idx)*4 +: 4] = d;
        return r;
    endfunction

endpackage

// File: rtl/digit_editor_if.sv
// Panel bus: raw keys and switches in, edited value and display hints out.
interface digit_editor_if;
    logic [3:0]  Key;
    logic [7:0]  Sw;
    logic [31:0] value;
    logic [2:0]  cursor;
    logic        edit_mode;
    logic [7:0]  blank_mask;
    logic        commit;

    // Panel side: drives keys/switches, observes editor outputs.
    modport master (output Key, Sw,
                    input  value, cursor, edit_mode, blank_mask, commit);

    // Editor side.
    modport slave  (input  Key, Sw,
                    output value, cursor, edit_mode, blank_mask, commit);
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, and a one-cycle
// press pulse on an accepted released->pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous key into the clock domain (idle = released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered edge detect on the debounced level; releases are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/digit_editor.sv
// Front-panel digit editor: debounced keys drive a VIEW/EDIT machine that
// edits a 32-bit hex value, with cursor and blink mask for the scanner.
module digit_editor
    import panel_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 65536,
    parameter int          BLINK_BIT       = 23,
    parameter logic [31:0] INIT_VALUE      = 32'h0A1B2C3D
) (
    input  logic           clk,
    input  logic           rst_n,
    digit_editor_if.slave  bus
);
    logic [3:0]         w_press;
    logic [7:0]         r_sw1;
    logic [7:0]         r_sw2;
    logic               w_unused_sw;

    state_t             r_state,  w_state_nx;
    logic [31:0]        r_value,  w_value_nx;
    logic [2:0]         r_cursor, w_cursor_nx;
    logic [BLINK_BIT:0] r_blink,  w_blink_nx;
    logic [7:0]         r_blank,  w_blank_nx;
    logic               r_commit, w_commit_nx;
    logic               w_evt;
    logic [3:0]         w_digit;
    logic [3:0]         w_digit_nx;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_key  (bus.Key[g]),
            .o_press(w_press[g])
        );
    end

    // Switches are quasi-static but still synchronized before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw1 <= '0;
            r_sw2 <= '0;
        end else begin
            r_sw1 <= bus.Sw;
            r_sw2 <= r_sw1;
        end
    end

    // Switches 6..4 have no function on this panel.
    assign w_unused_sw = ^r_sw2[6:4];

    // State, value, cursor, blink and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_VIEW;
            r_value  <= INIT_VALUE;
            r_cursor <= '0;
            r_blink  <= '0;
            r_blank  <= '0;
            r_commit <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_value  <= w_value_nx;
            r_cursor <= w_cursor_nx;
            r_blink  <= w_blink_nx;
            r_blank  <= w_blank_nx;
            r_commit <= w_commit_nx;
        end
    end

    // Next-state: one press acted on per cycle, priority EDIT > LEFT > RIGHT > DIGIT.
    always_comb begin
        w_state_nx  = r_state;
        w_value_nx  = r_value;
        w_cursor_nx = r_cursor;
        w_commit_nx = 1'b0;
        w_evt       = 1'b0;
        w_digit     = r_value[int'(r_cursor)*4 +: 4];
        w_digit_nx  = w_digit;

        case (r_state)
            ST_VIEW: begin
                if (w_press[KEY_EDIT]) begin
                    w_state_nx = ST_EDIT;
                    w_evt      = 1'b1;
                end
            end
            ST_EDIT: begin
                if (w_press[KEY_EDIT]) begin
                    w_state_nx  = ST_VIEW;
                    w_commit_nx = 1'b1;
                    w_evt       = 1'b1;
                end else if (w_press[KEY_LEFT]) begin
                    w_cursor_nx = r_cursor + 3'd1;
                    w_evt       = 1'b1;
                end else if (w_press[KEY_RIGHT]) begin
                    w_cursor_nx = r_cursor - 3'd1;
                    w_evt       = 1'b1;
                end else if (w_press[KEY_DIGIT]) begin
                    if (r_sw2[SW_LOAD])
                        w_digit_nx = r_sw2[3:0];
                    else if (r_sw2[SW_DOWN])
                        w_digit_nx = w_digit - 4'd1;
                    else
                        w_digit_nx = w_digit + 4'd1;
                    w_value_nx = set_digit(r_value, r_cursor, w_digit_nx);
                    w_evt      = 1'b1;
                end
            end
            default: w_state_nx = ST_VIEW;
        endcase

        // Restart the blink phase on every accepted event so the edit shows at once.
        w_blink_nx = w_evt ? '0 : r_blink + 1'b1;

        // Mask follows the new cursor so it never lags the cursor output.
        w_blank_nx = '0;
        if (w_state_nx == ST_EDIT)
            w_blank_nx[w_cursor_nx] = w_blink_nx[BLINK_BIT];
    end

    assign bus.value      = r_value;
    assign bus.cursor     = r_cursor;
    assign bus.edit_mode  = (r_state == ST_EDIT);
    assign bus.blank_mask = r_blank;
    assign bus.commit     = r_commit;

endmodule
